// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 64-way round-robin arbiter:
//   N_REQ       - number of requesters (64)
//   IDX_W       - width of a requester index (6)
//   arb_state_t - arbiter FSM state encoding {IDLE, BUSY}
//   rr_pick     - round-robin winner selection starting at a search pointer
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 64;
  localparam int IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Rotate the request vector right by ptr so that requester ptr lands on
  // bit 0, take the lowest set bit, then add ptr back. The IDX_W-bit add
  // wraps modulo 64, which gives the 63 -> 0 scan order for free.
  // Callers only use the result when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pe;
    rot = N_REQ'({req, req} >> ptr);
    pe  = {IDX_W{1'b0}};
    // Scan downward so the last hit, the lowest set bit, wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pe = IDX_W'(i);
      end else begin
        pe = pe;
      end
    end
    return pe + ptr;
  endfunction

endpackage

// File: rtl/dec_6_64.sv
// -----------------------------------------------------------------------------
// dec_6_64
// 6-to-64 one-hot decoder.
//   idx    in  6  : binary index
//   onehot out 64 : bit idx set, all others clear
// -----------------------------------------------------------------------------
module dec_6_64
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  assign onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/rr_arb_64.sv
// -----------------------------------------------------------------------------
// rr_arb_64
// Round-robin arbiter sharing one resource among 64 requesters. The winner's
// index is registered and expanded to a one-hot grant through dec_6_64.
// Every grant is followed by one dead IDLE cycle before the next one.
//   MAX_HOLD    param : max consecutive granted cycles (0 = unlimited)
//   clk         in  1 : clock, rising edge
//   reset       in  1 : synchronous active-high reset
//   req         in 64 : level-sensitive request vector
//   grant       out 64: one-hot grant, zero when idle
//   grant_valid out 1 : high while a grant is held
//   grant_idx   out 6 : current grantee index, 0 when idle
// -----------------------------------------------------------------------------
module rr_arb_64
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_SAT = {HC_W{1'b1}};

  arb_state_t       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [HC_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [IDX_W-1:0] grant_idx_r, grant_idx_s;
  logic [N_REQ-1:0] dec_s;
  logic             expire_s;

  // Forced expiry once the grant has been held MAX_HOLD cycles.
  assign expire_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_MAX);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      hold_cnt_r  <= {HC_W{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      grant_idx_r <= grant_idx_s;
    end
  end

  // Next-state logic: pick a winner from IDLE, release or expire from BUSY.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    grant_idx_s = grant_idx_r;
    case (state_r)
      IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          state_s     = BUSY;
          grant_idx_s = rr_pick(req, ptr_r);
          hold_cnt_s  = {{(HC_W-1){1'b0}}, 1'b1};
        end else begin
          state_s     = IDLE;
        end
      end
      BUSY: begin
        // Release and expiry share one path; release simply takes priority.
        if (!req[grant_idx_r] || expire_s) begin
          state_s     = IDLE;
          ptr_s       = grant_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          hold_cnt_s  = {HC_W{1'b0}};
          grant_idx_s = {IDX_W{1'b0}};
        end else begin
          state_s = BUSY;
          // Saturation only matters for the unlimited (MAX_HOLD = 0) case.
          if (hold_cnt_r != HOLD_SAT) begin
            hold_cnt_s = hold_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
        end
      end
      default: begin
        state_s     = IDLE;
        ptr_s       = {IDX_W{1'b0}};
        hold_cnt_s  = {HC_W{1'b0}};
        grant_idx_s = {IDX_W{1'b0}};
      end
    endcase
  end

  dec_6_64 u_dec (
    .idx    (grant_idx_r),
    .onehot (dec_s)
  );

  assign grant_valid = (state_r == BUSY);
  assign grant_idx   = grant_idx_r;
  assign grant       = dec_s & {N_REQ{grant_valid}};

endmodule

// File: tb/tb_rr_arb_64.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_64
// Directed self-checking bench for rr_arb_64 (MAX_HOLD = 4). Inputs change
// 1 time unit after the rising edge; outputs are checked at that same point,
// i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_arb_64;

  logic        clk;
  logic        reset;
  logic [63:0] req;
  logic [63:0] grant;
  logic        grant_valid;
  logic [5:0]  grant_idx;

  int checks = 0;
  int errors = 0;

  rr_arb_64 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 64'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 64'd0 || grant_valid !== 1'b0 || grant_idx !== 6'd0) begin
        errors++;
        $display("FAIL reset_c%0d got grant=%h valid=%b idx=%0d want 0/0/0", c, grant, grant_valid, grant_idx);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_order();
    req = (64'd1 << 5) | (64'd1 << 40);
    tick();
    checks++;
    if (grant_idx !== 6'd5 || grant !== (64'd1 << 5) || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL order_first got idx=%0d grant=%h valid=%b want idx=5", grant_idx, grant, grant_valid);
    end
    req = 64'd1 << 40;
    tick();
    checks++;
    if (grant !== 64'd0 || grant_valid !== 1'b0 || grant_idx !== 6'd0) begin
      errors++;
      $display("FAIL order_dead got idx=%0d grant=%h valid=%b want idle", grant_idx, grant, grant_valid);
    end
    tick();
    checks++;
    if (grant_idx !== 6'd40 || grant !== (64'd1 << 40) || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL order_second got idx=%0d grant=%h valid=%b want idx=40", grant_idx, grant, grant_valid);
    end
    req = 64'd0;
    tick();  // release, ptr -> 41
  endtask

  task automatic test_wrap();
    req = 64'd1 << 62;
    tick();
    checks++;
    if (grant_idx !== 6'd62 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_62 got idx=%0d valid=%b want idx=62", grant_idx, grant_valid);
    end
    req = 64'd0;
    tick();  // ptr -> 63
    req = (64'd1 << 1) | (64'd1 << 63);
    tick();
    checks++;
    if (grant_idx !== 6'd63 || grant !== (64'd1 << 63) || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_63 got idx=%0d grant=%h want idx=63", grant_idx, grant);
    end
    req = 64'd1 << 1;
    tick();
    checks++;
    if (grant !== 64'd0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_dead got grant=%h valid=%b want idle", grant, grant_valid);
    end
    tick();
    checks++;
    if (grant_idx !== 6'd1 || grant !== (64'd1 << 1) || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_1 got idx=%0d grant=%h want idx=1", grant_idx, grant);
    end
    req = 64'd0;
    tick();  // ptr -> 2
  endtask

  task automatic test_hold_expiry();
    logic exp_g;
    req = 64'd1 << 7;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_g = ((c % 5) < 4);
      checks++;
      if (grant[7] !== exp_g || grant_valid !== exp_g) begin
        errors++;
        $display("FAIL hold_c%0d got grant7=%b valid=%b want %b", c, grant[7], grant_valid, exp_g);
      end
    end
    req = 64'd0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 64'd1 << 50;
    tick();
    checks++;
    if (grant_idx !== 6'd50 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant got idx=%0d valid=%b want idx=50", grant_idx, grant_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 64'd0 || grant_valid !== 1'b0 || grant_idx !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_clear got grant=%h valid=%b idx=%0d want 0", grant, grant_valid, grant_idx);
    end
    reset = 1'b0;
    req   = (64'd1 << 3) | (64'd1 << 60);
    tick();
    checks++;
    if (grant_idx !== 6'd3 || grant !== (64'd1 << 3)) begin
      errors++;
      $display("FAIL rstmid_ptr0 got idx=%0d grant=%h want idx=3", grant_idx, grant);
    end
    req = 64'd0;
    tick();
  endtask

  task automatic test_fairness();
    logic [63:0] rv;
    logic [63:0] one;
    reset = 1'b1;
    req   = 64'd0;
    tick();
    reset = 1'b0;
    rv    = {64{1'b1}};
    req   = rv;
    for (int k = 0; k <= 64; k++) begin
      tick();
      one = 64'd1 << (k % 64);
      checks++;
      if (grant_idx !== 6'(k % 64) || grant !== one || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL fair_grant_%0d got idx=%0d valid=%b want idx=%0d", k, grant_idx, grant_valid, k % 64);
      end
      rv  = rv & ~one;
      req = rv;
      tick();
      checks++;
      if (grant !== 64'd0 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL fair_dead_%0d got grant=%h valid=%b want idle", k, grant, grant_valid);
      end
      rv  = rv | one;
      req = rv;
    end
    req = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 64'd0;
    test_reset();
    test_order();
    test_wrap();
    test_hold_expiry();
    test_reset_mid();
    test_fairness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_64.md
# rr_arb_64

Round-robin arbiter that shares one resource among 64 requesters and issues a one-hot grant vector. The winner's 6-bit index is registered, and the existing `dec_6_64` decoder expands it into the 64-bit grant. It sits between the requester bank and the shared resource, and is the sequencing front end for any datapath that is selected one-of-64.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may stay asserted. 0 means unlimited.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  64: request vector; bit i is requester i, level-sensitive.
- `grant`  out  64: one-hot grant, or all-zero when idle.
- `grant_valid`  out  1: high whenever `grant` is non-zero.
- `grant_idx`  out  6: index of the current grantee; 0 when `grant_valid` is low.

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: one grant held.
- Internal registers:
  - `ptr` (6 b): search start index.
  - `hold_cnt`: width clog2(MAX_HOLD+1), minimum 1.
- Reset values: state=IDLE, `ptr`=0, `hold_cnt`=0, `grant`=0, `grant_valid`=0, `grant_idx`=0.
- IDLE behaviour:
  - If `req`==0, remain in IDLE.
  - Otherwise select the first set bit at or above `ptr`, scanning upward with wrap 63→0.
  - Register the winner's index into `grant_idx`, move to BUSY, and set `hold_cnt`=1.
- BUSY behaviour:
  - If `req[grant_idx]`==0 in the current cycle: release.
  - Else if MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD: forced expiry.
  - Otherwise stay in BUSY and increment `hold_cnt` (saturates when MAX_HOLD=0).
- Release and expiry are handled identically:
  - Next state is IDLE, `grant`→0.
  - `ptr` ← `grant_idx`+1 mod 64 (63 wraps to 0).
  - `hold_cnt` ← 0.
- Output derivation: `grant` = `dec_6_64(grant_idx)` ANDed with `grant_valid`. `grant_valid` = (state==BUSY).
- Requests arriving while BUSY are ignored until the next IDLE cycle. There is no pre-emption.
- A requester whose grant expired while still requesting competes again from the advanced `ptr`. If it is the only requester, it is re-granted.

## Timing
- Request to grant latency: the request is sampled in IDLE at edge k, and the grant is visible after edge k (1 cycle).
- Minimum grant length is 1 cycle. A requester that drops `req` during its first granted cycle loses the grant at the next edge.
- Between consecutive grants there is exactly one dead cycle (IDLE, `grant`=0), even when other requests are pending.
- With MAX_HOLD=M and a persistent request, the grant is high for M cycles, then low for 1, repeating.
- Simultaneous release and expiry in the same cycle are treated as release. The `ptr` update is the same either way.
- Reset mid-grant: `grant`=0 after the reset edge and `ptr`=0. Requests present during the reset cycle are not granted in that cycle.
- All outputs come straight from registers or the decoder, with no combinational path from `req` to `grant`.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=64 and `IDX_W`=6.
  - State enum `arb_state_t` {IDLE, BUSY}.
  - Function `rr_pick(req, ptr)` returning the winner index. Implement it as rotate by `ptr`, priority encode, then add `ptr` mod 64.
- Sub-module: existing `dec_6_64` instantiated once for the grant one-hot. No other sub-modules.

## Test plan
- Reset check: assert `reset` for 2 cycles with `req`=0 → `grant`=0, `grant_valid`=0, `grant_idx`=0 on every cycle.
- Ordering and dead cycle:
  - After reset, set `req` bits 5 and 40 together → `grant_idx`=5 one cycle later.
  - Drop `req[5]` → 1 idle cycle, then `grant_idx`=40.
- Wrap-around:
  - Grant and release index 62 (`ptr`=63).
  - Then `req` bits 1 and 63 → 63 granted first. Release it → after the dead cycle, 1 is granted.
- Hold expiry: MAX_HOLD=4, `req[7]` held high alone → `grant[7]` repeats the pattern high 4, low 1.
- Reset mid-operation:
  - While index 50 is granted, pulse `reset` → `grant`=0 after the edge.
  - Then `req` bits 3 and 60 → 3 granted.
- Fairness: all 64 `req` high, each grantee drops its `req` in its first granted cycle and re-raises it next cycle → grant indices 0,1,…,63,0 at one grant per 2 cycles.
